// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM data-processing decode/issue slice.
package arm_pkg;

  // ALU micro-ops (uop = {1'b0, opcode}); NOP marks a non-issuing cycle
  typedef enum logic [4:0] {
    UOP_AND = 5'b00000, UOP_EOR = 5'b00001, UOP_SUB = 5'b00010, UOP_RSB = 5'b00011,
    UOP_ADD = 5'b00100, UOP_ADC = 5'b00101, UOP_SBC = 5'b00110, UOP_RSC = 5'b00111,
    UOP_TST = 5'b01000, UOP_TEQ = 5'b01001, UOP_CMP = 5'b01010, UOP_CMN = 5'b01011,
    UOP_ORR = 5'b01100, UOP_MOV = 5'b01101, UOP_BIC = 5'b01110, UOP_MVN = 5'b01111,
    UOP_NOP = 5'b11111
  } uop_e;

  // Condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the flags vector from regs
  typedef enum int {FLAG_V = 0, FLAG_N = 1, FLAG_C = 2, FLAG_Z = 3} flag_idx_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EVAL = 2'd1, ST_ISSUE = 2'd2} state_t;

  // Field view of a data-processing instruction word
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  cls;
    logic        i;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
  } ins_t;

  // 8-bit immediate rotated right by twice the 4-bit rotate field
  function automatic logic [31:0] ror_imm(input logic [11:0] op2);
    logic [63:0] dbl;
    logic [63:0] sh;
    dbl = {24'h0, op2[7:0], 24'h0, op2[7:0]};
    sh  = dbl >> {op2[11:8], 1'b0};
    return sh[31:0];
  endfunction

  // TST/TEQ/CMP/CMN only set flags and never write Rd
  function automatic logic is_test_op(input logic [3:0] opcode);
    return opcode[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator. With COND_EXEC_EN undefined every cond except
// NV passes and the flags are ignored.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
`ifdef COND_EXEC_EN
  logic z, c, n, v;
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // full ARM condition table
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
`else
  logic flags_unused;
  assign flags_unused = flags[FLAG_Z] ^ flags[FLAG_C] ^ flags[FLAG_N] ^ flags[FLAG_V];
  assign pass = (cond != COND_NV);
`endif
endmodule

// File: rtl/decode_issue.sv
// In-order decode/issue stage for ARM data-processing ops.
// IDLE -> EVAL -> ISSUE; outputs are registered at the end of EVAL and live
// for the single ISSUE cycle. Optional macro COND_EXEC_EN enables condition
// evaluation against the live flags.
module decode_issue
  import arm_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ins_valid,
  input  logic [31:0] ins_data,
  output logic        ins_ready,
  input  logic [3:0]  flags,
  output logic [3:0]  sel_p0,
  output logic [3:0]  sel_p1,
  output logic [3:0]  sel_in,
  output logic [4:0]  uop,
  output logic [31:0] imm,
  output logic        imm_sel,
  output logic        wr_en,
  output logic        flags_wr,
  output logic [31:0] pc,
  output logic        illegal,
  output logic        skipped
);
  state_t state;
  ins_t   ins_q;
  logic   pass, writes, bad;

  cond_check u_cond (.cond(ins_q.cond), .flags(flags), .pass(pass));

  assign ins_ready = (state == ST_IDLE);

  // legality of the captured word
  always_comb begin
    writes = !is_test_op(ins_q.opcode);
    bad    = (ins_q.cls != 2'b00) || (ins_q.cond == COND_NV) ||
             (writes && ins_q.rd == 4'hF) ||
             (!ins_q.i && ins_q.op2[11:4] != 8'h00);
  end

  // FSM plus registered issue outputs; strobes default to idle every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ins_q    <= '0;
      sel_p0   <= '0;
      sel_p1   <= '0;
      sel_in   <= '0;
      uop      <= UOP_NOP;
      imm      <= '0;
      imm_sel  <= 1'b0;
      wr_en    <= 1'b0;
      flags_wr <= 1'b0;
      pc       <= '0;
      illegal  <= 1'b0;
      skipped  <= 1'b0;
    end else begin
      uop      <= UOP_NOP;
      wr_en    <= 1'b0;
      flags_wr <= 1'b0;
      illegal  <= 1'b0;
      skipped  <= 1'b0;
      case (state)
        ST_IDLE: if (ins_valid) begin
          ins_q <= ins_data;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          state   <= ST_ISSUE;
          pc      <= pc + 32'd4;
          sel_p0  <= ins_q.rn;
          sel_in  <= ins_q.rd;
          imm_sel <= ins_q.i;
          if (ins_q.i) imm    <= ror_imm(ins_q.op2);
          else         sel_p1 <= ins_q.op2[3:0];
          if (bad) begin
            illegal <= 1'b1;
          end else if (!pass) begin
`ifdef COND_EXEC_EN
            skipped <= 1'b1;
`else
            skipped <= 1'b0;
`endif
          end else begin
            uop      <= {1'b0, ins_q.opcode};
            wr_en    <= writes;
            flags_wr <= !writes | ins_q.s;
          end
        end
        ST_ISSUE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed words, randomized words
// against a field-level reference model, back-to-back accept and reset abort.
module tb_decode_issue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ins_valid = 1'b0;
  logic [31:0] ins_data = '0;
  logic [3:0]  flags = '0;
  logic        ins_ready;
  logic [3:0]  sel_p0, sel_p1, sel_in;
  logic [4:0]  uop;
  logic [31:0] imm, pc;
  logic        imm_sel, wr_en, flags_wr, illegal, skipped;

  int tests = 0;
  int fails = 0;
  logic [31:0] pc_m = '0;

  always #5 clock = ~clock;

  decode_issue dut (
    .clock(clock), .reset(reset), .ins_valid(ins_valid), .ins_data(ins_data),
    .ins_ready(ins_ready), .flags(flags), .sel_p0(sel_p0), .sel_p1(sel_p1),
    .sel_in(sel_in), .uop(uop), .imm(imm), .imm_sel(imm_sel), .wr_en(wr_en),
    .flags_wr(flags_wr), .pc(pc), .illegal(illegal), .skipped(skipped)
  );

  typedef struct {
    logic [4:0]  uop;
    logic        wr, fw, ill, skp, isel, issued;
    logic [3:0]  p0, p1, rd;
    logic [31:0] imm;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // condition outcome from the architectural table
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    bit z, cy, n, v;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c != 4'hF) || (f === 4'hx);
`endif
  endfunction

  // expected ISSUE-cycle outputs for one word
  function automatic exp_t model(input logic [31:0] w, input logic [3:0] f);
    exp_t e;
    logic [31:0] r;
    int op;
    bit cmp_class;
    op = int'(w[24:21]);
    cmp_class = (op >= 8 && op <= 11);
    e.ill = (w[27:26] != 2'b00) || (w[31:28] == 4'hF) ||
            (!cmp_class && w[15:12] == 4'hF) || (!w[25] && w[11:4] != 8'h00);
    e.skp = !e.ill && !cond_ok(w[31:28], f);
    e.issued = !e.ill && !e.skp;
    e.uop  = e.issued ? 5'(op) : 5'b11111;
    e.wr   = e.issued && !cmp_class;
    e.fw   = e.issued && (cmp_class || w[20]);
    e.p0   = w[19:16];
    e.rd   = w[15:12];
    e.p1   = w[3:0];
    e.isel = w[25];
    r = {24'h0, w[7:0]};
    for (int k = 0; k < 2 * int'(w[11:8]); k++) r = {r[0], r[31:1]};
    e.imm = r;
    return e;
  endfunction

  task automatic run(input string tag, input logic [31:0] w, input logic [3:0] f);
    exp_t e;
    int n;
    n = 0;
    while (!ins_ready && n < 10) begin @(posedge clock); #1; n++; end
    chk({tag, ":ready"}, ins_ready, 1);
    e = model(w, f);
    ins_valid = 1'b1; ins_data = w; flags = f;
    @(posedge clock); #1;
    ins_valid = 1'b0; ins_data = $urandom;
    chk({tag, ":busy"}, ins_ready, 0);
    @(posedge clock); #1;
    pc_m += 32'd4;
    flags = 4'($urandom);
    chk({tag, ":uop"}, uop, e.uop);
    chk({tag, ":wr_en"}, wr_en, e.wr);
    chk({tag, ":flags_wr"}, flags_wr, e.fw);
    chk({tag, ":illegal"}, illegal, e.ill);
    chk({tag, ":skipped"}, skipped, e.skp);
    chk({tag, ":pc"}, pc, pc_m);
    if (e.issued) begin
      chk({tag, ":sel_p0"}, sel_p0, e.p0);
      chk({tag, ":sel_in"}, sel_in, e.rd);
      chk({tag, ":imm_sel"}, imm_sel, e.isel);
      if (w[25]) chk({tag, ":imm"}, imm, e.imm);
      else       chk({tag, ":sel_p1"}, sel_p1, e.p1);
    end
    @(posedge clock); #1;
    chk({tag, ":idle_uop"}, uop, 5'b11111);
    chk({tag, ":idle_wr"}, {wr_en, flags_wr, illegal, skipped}, 4'b0000);
    chk({tag, ":idle_ready"}, ins_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst:ready", ins_ready, 1);
    chk("rst:uop", uop, 5'b11111);
    chk("rst:pc", pc, 0);
    chk("rst:sels", {sel_p0, sel_p1, sel_in}, 12'h000);
    chk("rst:imm", imm, 0);
    chk("rst:strobes", {imm_sel, wr_en, flags_wr, illegal, skipped}, 5'b00000);
    reset = 1'b0;

    // directed words
    run("sub", 32'hE0412000, 4'b0000);
    run("mov_imm", 32'hE3A034FF, 4'b0000);
    run("addeq_f0", 32'h00800001, 4'b0000);
    run("addeq_z", 32'h00800001, 4'b1000);
    run("cmp", 32'hE1510000, 4'b0000);
    run("branch", 32'hEA000000, 4'b0000);
    run("mov_pc", 32'hE1A0F000, 4'b0000);
    run("cond_nv", 32'hF0812003, 4'b1111);
    run("shift", 32'hE0812083, 4'b0000);
    run("gt", 32'hC0912003, 4'b0011);
    run("hi", 32'h80912003, 4'b0100);

    // randomized words, biased toward legal encodings
    for (int t = 0; t < 60; t++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[27:26] = 2'b00;
      if (!w[25] && $urandom_range(3) != 0) w[11:4] = 8'h00;
      if ($urandom_range(2) == 0) w[31:28] = 4'hE;
      if (w[15:12] == 4'hF && $urandom_range(1) == 0) w[15:12] = 4'h7;
      run("rand", w, 4'($urandom));
    end

    // back-to-back with valid held, then reset during second EVAL
    ins_valid = 1'b1; ins_data = 32'hE0812003; flags = 4'b0000;
    @(posedge clock); #1;
    ins_data = 32'hE1510000;
    chk("b2b:t1_busy", ins_ready, 0);
    @(posedge clock); #1;
    pc_m += 32'd4;
    chk("b2b:t2_busy", ins_ready, 0);
    chk("b2b:t2_wr", wr_en, 1);
    chk("b2b:t2_uop", uop, 5'b00100);
    chk("b2b:t2_pc", pc, pc_m);
    @(posedge clock); #1;
    chk("b2b:t3_ready", ins_ready, 1);
    @(posedge clock); #1;
    chk("b2b:second_acc", ins_ready, 0);
    ins_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    pc_m = '0;
    chk("abort:ready", ins_ready, 1);
    chk("abort:pc", pc, 0);
    chk("abort:strobes", {wr_en, flags_wr, illegal, skipped}, 4'b0000);
    chk("abort:uop", uop, 5'b11111);
    @(posedge clock); #1;
    chk("abort:no_issue", {wr_en, flags_wr}, 2'b00);
    chk("abort:still_idle", ins_ready, 1);

    // pc restarts from 0 after the abort
    run("post_rst", 32'hE0412000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

In-order decode/issue stage for the data-processing subset of ARM. It accepts 32-bit instruction words over a valid/ready handshake and evaluates the condition field against the live flags from `regs`. It then drives one issue cycle of register selects, ALU micro-op, immediate and write strobes into the execute stage (`regs` + `ALU`). It is the producing end of the execute-stage control interface.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ins_valid  in  1  instruction word available
- ins_data  in  32  ARM instruction word
- ins_ready  out  1  block can accept; reset 1
- flags  in  4  current flags from `regs`, order [Z,C,N,V] (bit3=Z … bit0=V)
- sel_p0  out  4  Rn select; reset 0
- sel_p1  out  4  Rm select; reset 0
- sel_in  out  4  Rd select; reset 0
- uop  out  5  ALU micro-op; reset 5'b11111 (NOP)
- imm  out  32  decoded immediate; reset 0
- imm_sel  out  1  1 = RHS from `imm`, 0 = from p1; reset 0
- wr_en  out  1  write ALU result to `sel_in`; reset 0
- flags_wr  out  1  latch ALU flags; reset 0
- pc  out  32  address of next instruction; reset 0
- illegal  out  1  one-cycle pulse, unsupported encoding; reset 0
- skipped  out  1  one-cycle pulse, condition failed; reset 0

## Operation
- FSM: IDLE → EVAL → ISSUE → IDLE. `ins_ready` = (state == IDLE).
- IDLE: on `ins_valid & ins_ready`, capture `ins_data`, go to EVAL.
- EVAL: decode the captured word and evaluate the condition with `flags` sampled in this cycle. Load the output registers at the closing edge. pc += 4 at the closing edge, whatever the outcome.
- ISSUE: outputs valid for exactly one cycle. Then go to IDLE.
- Decode: cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], op2[11:0].
- uop = {1'b0, opcode}, e.g. AND=00000, SUB=00010, ADD=00100, CMP=01010, MOV=01101, MVN=01111.
- Immediate (I=1): imm = zero-extended op2[7:0] rotated right by 2*op2[11:8]; imm_sel=1.
- Register (I=0): sel_p1 = op2[3:0]; op2[11:4] ≠ 0 → illegal.
- TST/TEQ/CMP/CMN: wr_en=0, flags_wr=1. All other ops: wr_en=1, flags_wr=S.
- Illegal when any of: bits[27:26] ≠ 00; cond = 1111; Rd = 15 on a writing op; nonzero shift.
- Illegal or condition failed → ISSUE cycle carries uop=11111, wr_en=0, flags_wr=0, plus an `illegal` or `skipped` pulse.
- Conditions: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N≠V, GT !Z&(N==V), LE Z|(N≠V), AL 1.
- Outside ISSUE: uop=11111, wr_en=flags_wr=illegal=skipped=0. Selects and imm hold their last values.

## Timing
- Accept at edge T. EVAL during cycle T+1. ISSUE during cycle T+2. `regs` write at the edge ending ISSUE. `ins_ready` high again in cycle T+3.
- Throughput: one instruction per 3 cycles. With `ins_valid` held high, back-to-back words are accepted 3 cycles apart.
- Flags written by instruction k are visible during EVAL of instruction k+1, so there is no hazard.
- `ins_data` is sampled only at the accept edge and may change afterwards.
- pc wraps 0xFFFFFFFC → 0.
- Reset in any state: next cycle IDLE, all outputs at reset values, captured word discarded, no wr_en/flags_wr pulse.

## Configuration
- COND_EXEC_EN defined: full condition evaluation as above.
- COND_EXEC_EN undefined: every cond except 1111 is treated as AL, `skipped` is tied 0, and `flags` is unused. cond = 1111 is still illegal.

## Structure
- Package `arm_pkg`:
  - uop constants, including UOP_NOP = 5'b11111
  - cond-code constants
  - flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0)
  - FSM state encoding
- Sub-module `cond_check`: combinational, inputs cond[3:0] and flags[3:0], output pass.

## Test plan
- Reset, then 0xE0412000 (SUB r2,r1,r0), flags=0 → at T+2: uop=00010, sel_p0=1, sel_p1=0, sel_in=2, imm_sel=0, wr_en=1, flags_wr=0; pc=4.
- 0xE3A034FF (MOV r3,#0xFF000000) → uop=01101, imm_sel=1, imm=0xFF000000, sel_in=3, wr_en=1.
- 0x00800001 (ADDEQ r0,r0,r1):
  - flags=0000 → skipped=1, uop=11111, wr_en=0, pc still +4.
  - flags=1000 → uop=00100, wr_en=1.
- 0xE1510000 (CMP r1,r0) → uop=01010, sel_p0=1, sel_p1=0, wr_en=0, flags_wr=1.
- 0xEA000000 (branch) and 0xE1A0F000 (MOV pc,r0) → each gives illegal=1, wr_en=0, uop=11111.
- Two words with ins_valid held high → accepted 3 cycles apart. Reset asserted during EVAL of the second → next cycle ins_ready=1, pc=0, no wr_en pulse.
